chaotic_iter_seq: RTL
=====================

# chaotic_iter_seq

Iteration sequencer for the chaotic-map datapath: seeds an external equation block, feeds each next-state result back as the new present state, and discards a programmable burn-in transient. It then streams a programmable number of state samples (or runs continuously) over a valid/ready port to the downstream key/sequence generator. It is generic in state dimension count and word width, handles back-pressure, can be stopped on request, and flags an equation-block timeout.

## Interface
- DATA_WIDTH, 64, width of one state component; must match the floating-point IP word.
- NDIM, 3, number of state dimensions.
- CNT_WIDTH, 32, width of the burn-in and sample counters.
- TIMEOUT, 255, maximum cycles to wait for an equation result (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request; honoured only in IDLE.
- stop  in  1  one-cycle abort request.
- seed  in  NDIM*DATA_WIDTH  initial state; component 0 in the LSBs.
- burn_in  in  CNT_WIDTH  number of iterations discarded before the first sample.
- num_samples  in  CNT_WIDTH  number of samples to emit; 0 means continuous.
- eq_in_valid  out  1  one-cycle pulse presenting the present state to the equation block.
- eq_state_out  out  NDIM*DATA_WIDTH  present state.
- eq_out_valid  in  1  next state is valid (one cycle).
- eq_state_in  in  NDIM*DATA_WIDTH  next state.
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  NDIM*DATA_WIDTH  sample.
- out_index  out  CNT_WIDTH  sample number, starting at 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion or stop.
- timeout_err  out  1  sticky error flag; cleared by an accepted start.

## Operation
- States: IDLE, ISSUE, WAIT, EMIT, FINISH, ERR.
- IDLE, on start: latch seed into the state register, burn_in into the burn counter, and num_samples into the target. Clear the sample counter and timeout_err. Go to ISSUE.
- ISSUE: assert eq_in_valid for one cycle with eq_state_out set to the state register. Clear the wait counter. Go to WAIT.
- WAIT, on eq_out_valid: load eq_state_in into the state register.
  - If the burn counter is nonzero: decrement it and go to ISSUE.
  - Otherwise go to EMIT.
- WAIT timeout: the wait counter increments each cycle without eq_out_valid. When it reaches TIMEOUT, set timeout_err and go to ERR.
- EMIT: out_valid=1; out_data = state register; out_index = sample counter. Data and index are held stable until out_ready. On handshake, increment the sample counter.
  - If num_samples≠0 and the new count equals num_samples: go to FINISH.
  - Otherwise go to ISSUE.
- FINISH: done=1 for one cycle, then go to IDLE.
- ERR: held until the next start, which is accepted exactly as in IDLE. busy=1 in ERR.
- stop: latched into a pending flag in any non-IDLE state.
  - In ISSUE or EMIT, the pending flag takes the FSM to FINISH on the next transition point.
  - In EMIT without a handshake, it drops out_valid and goes directly to FINISH.
  - In WAIT, the FSM waits for the in-flight result (or timeout) and discards it before going to FINISH.
  - The pending flag is cleared in FINISH.
- eq_out_valid outside WAIT is ignored. start while busy is ignored.
- Counter wrap: in continuous mode the sample counter wraps from 2^CNT_WIDTH−1 to 0 with no error.
- burn_in=0: the first result is emitted as sample 0.

## Timing
- Reset values: every output and register is 0, the FSM is in IDLE, and the pending flag is clear.
- Asynchronous reset during any state aborts immediately, with no done pulse.
- start in cycle t gives eq_in_valid in cycle t+1.
- eq_out_valid in cycle t gives:
  - eq_in_valid in t+1 (burn-in), or
  - out_valid in t+1.
- Output handshake in cycle t gives eq_in_valid in t+1, or done in t+1.
- Per-iteration overhead is 2 cycles plus the equation latency L.
- Timeout: with no result, ERR is entered TIMEOUT+1 cycles after eq_in_valid.

## Structure
- Shared package chaotic_pkg holds:
  - the FSM state enum;
  - a state-vector type parameterised by NDIM/DATA_WIDTH;
  - a helper for component slicing.
- The wait timer is a natural sub-module, seq_timeout_cnt (clear, enable, expired), reused by other sequencers.
- The equation block stays outside this module; it is wired at the top level.

## Test plan
- Use a bench equation model with fixed latency L=5 that returns each component +1.
- NDIM=3, seed={0,0,0}, burn_in=2, num_samples=3, out_ready=1:
  - samples {3,3,3}, {4,4,4}, {5,5,5} with out_index 0,1,2;
  - done pulse one cycle after the last handshake;
  - busy drops the following cycle.
- Same run with out_ready low for 4 cycles on sample 1: out_data/out_index stable throughout, and no eq_in_valid until the handshake.
- Equation model silenced after 1 result, TIMEOUT=10: timeout_err=1 exactly 11 cycles after the hung eq_in_valid. A new start clears it and the run completes.
- num_samples=0 with stop asserted during WAIT of sample 7: the in-flight result is discarded, there is no out_valid, done pulses, and 7 samples are emitted in total.
- start pulsed during WAIT is ignored (state unchanged). rst_n dropped mid-EMIT: all outputs are 0 asynchronously, and there is no done pulse.

Source files
------------

// File: rtl/chaotic_pkg.sv
// Shared types for the chaotic-map iteration sequencer:
// FSM state enum, default state-vector type, component slicing helper.
package chaotic_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NDIM       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT,
    ST_FINISH,
    ST_ERR
  } seq_state_t;

  typedef logic [DEF_NDIM-1:0][DEF_DATA_WIDTH-1:0] state_vec_t;

  // LSB position of component idx in a flat vector
  function automatic int comp_lsb(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Wait timer: clear/enable/expired, expired on the enabled cycle
// whose increment would reach LIMIT.
module seq_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expired = enable && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/chaotic_iter_seq.sv
// Iteration sequencer: seeds the equation block, burns in, then
// streams samples over valid/ready; stop, timeout, done, busy.
module chaotic_iter_seq
  import chaotic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NDIM       = DEF_NDIM,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [NDIM*DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]       burn_in,
  input  logic [CNT_WIDTH-1:0]       num_samples,
  output logic                       eq_in_valid,
  output logic [NDIM*DATA_WIDTH-1:0] eq_state_out,
  input  logic                       eq_out_valid,
  input  logic [NDIM*DATA_WIDTH-1:0] eq_state_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NDIM*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]       out_index,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  localparam int VW = NDIM * DATA_WIDTH;

  seq_state_t state, state_nx;

  logic [VW-1:0]        vec_q;
  logic [CNT_WIDTH-1:0] burn_q;
  logic [CNT_WIDTH-1:0] target_q;
  logic [CNT_WIDTH-1:0] idx_q;
  logic                 stop_pend;
  logic                 err_q;

  logic stop_any;
  logic start_ok;
  logic hs;
  logic last;
  logic take_res;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_exp;

  // a stop raised this cycle acts at once, like a pending one
  assign stop_any = stop | stop_pend;
  assign start_ok = start &&
    (state == ST_IDLE || state == ST_ERR);
  assign hs = (state == ST_EMIT) && out_ready;
  assign last = (target_q != '0) &&
    (idx_q + CNT_WIDTH'(1) == target_q);
  assign take_res = (state == ST_WAIT) &&
    eq_out_valid && !stop_any;

  seq_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clr),
    .enable (tmo_en),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    eq_in_valid = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    unique case (state)
      ST_IDLE, ST_ERR: begin
        if (start_ok) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmo_clr = 1'b1;
        // never launch a request that nobody will wait for
        eq_in_valid = !stop_any;
        state_nx = stop_any ? ST_FINISH : ST_WAIT;
      end
      ST_WAIT: begin
        tmo_en = !eq_out_valid;
        if (eq_out_valid) begin
          if (stop_any)
            state_nx = ST_FINISH;
          else if (burn_q != '0)
            state_nx = ST_ISSUE;
          else
            state_nx = ST_EMIT;
        end else if (tmo_exp) begin
          state_nx = ST_ERR;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (hs)
          state_nx = (stop_any || last) ?
            ST_FINISH : ST_ISSUE;
        else if (stop_any)
          state_nx = ST_FINISH;
      end
      ST_FINISH: begin
        done = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      burn_q    <= '0;
      target_q  <= '0;
      idx_q     <= '0;
      stop_pend <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        vec_q    <= seed;
        burn_q   <= burn_in;
        target_q <= num_samples;
        idx_q    <= '0;
        err_q    <= 1'b0;
      end
      if (take_res) begin
        vec_q <= eq_state_in;
        if (burn_q != '0)
          burn_q <= burn_q - CNT_WIDTH'(1);
      end
      // wraps freely in continuous mode
      if (hs) idx_q <= idx_q + CNT_WIDTH'(1);
      if (tmo_exp) err_q <= 1'b1;
      if (state == ST_FINISH || start_ok)
        stop_pend <= 1'b0;
      else if (stop && state != ST_IDLE)
        stop_pend <= 1'b1;
    end
  end

  assign eq_state_out = vec_q;
  assign out_data     = vec_q;
  assign out_index    = idx_q;
  assign busy         = (state != ST_IDLE);
  assign timeout_err  = err_q;

endmodule
